// File: rtl/clock_group_reset_sequencer_if.sv
// Request inputs and per-group reset outputs of the clock-group reset sequencer.
// The sequencer uses the master side; the requester/reset consumer uses the slave side.
interface clock_group_reset_sequencer_if;
  logic       io_async_req;
  logic       io_l2_reset_req;
  logic       auto_out_member_subsystem_sbus_0_reset;
  logic       auto_out_member_subsystem_sbus_1_reset;
  logic       io_ready;
  logic [1:0] io_state;

  modport master (
    input  io_async_req,
    input  io_l2_reset_req,
    output auto_out_member_subsystem_sbus_0_reset,
    output auto_out_member_subsystem_sbus_1_reset,
    output io_ready,
    output io_state
  );

  modport slave (
    output io_async_req,
    output io_l2_reset_req,
    input  auto_out_member_subsystem_sbus_0_reset,
    input  auto_out_member_subsystem_sbus_1_reset,
    input  io_ready,
    input  io_state
  );
endinterface

// File: rtl/clock_group_reset_sequencer.sv
// Releases the sbus group reset, then the L2 group reset after a stagger; supports an
// asynchronous full re-reset request and a synchronous L2-only re-reset request.
module clock_group_reset_sequencer #(
  parameter int SYNC_STAGES    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  clock_group_reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    HOLD_ALL = 2'd0,
    REL0     = 2'd1,
    RUN      = 2'd2,
    HOLD1    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   sbus0_rst_q;
  logic                   sbus1_rst_q;
  logic                   ready_q;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Next state: an external request overrides everything and pins the counter at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    if (req_s) begin
      state_nxt = HOLD_ALL;
      cnt_nxt   = '0;
    end else begin
      case (state)
        HOLD_ALL: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = REL0;
            cnt_nxt   = '0;
          end
        end
        REL0: begin
          if (cnt == STAGGER_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        RUN: begin
          cnt_nxt = '0;
          if (bus.io_l2_reset_req) begin
            state_nxt = HOLD1;
          end
        end
        HOLD1: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= '0;
      state       <= HOLD_ALL;
      cnt         <= '0;
      sbus0_rst_q <= 1'b1;
      sbus1_rst_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.io_async_req};
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sbus0_rst_q <= (state_nxt == HOLD_ALL);
      sbus1_rst_q <= (state_nxt != RUN);
      ready_q     <= (state_nxt == RUN);
    end
  end

  assign bus.auto_out_member_subsystem_sbus_0_reset = sbus0_rst_q;
  assign bus.auto_out_member_subsystem_sbus_1_reset = sbus1_rst_q;
  assign bus.io_ready                               = ready_q;
  assign bus.io_state                               = state;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for clock_group_reset_sequencer: a default instance (A) and a corner instance (B)
// checked every cycle against a release-timer model plus directed literal expectations.
module tb_clock_group_reset_sequencer;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n;

  always #5 clk = ~clk;

  clock_group_reset_sequencer_if ifa ();
  clock_group_reset_sequencer_if ifb ();

  clock_group_reset_sequencer dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (ifa.master)
  );

  clock_group_reset_sequencer #(
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (1),
    .STAGGER_CYCLES (1),
    .CNT_W          (8)
  ) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (ifb.master)
  );

  // Model: a group is released once enough quiet cycles (no reset, no synchronized
  // request) have accumulated; an accepted L2 request opens a countdown window.
  typedef struct packed {
    int         quiet;
    int         l2_left;
    logic [7:0] sq;
  } mstate_t;

  mstate_t ms [2] = '{'0, '0};

  function automatic int hc(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic int sc(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic int ns(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  function automatic mstate_t model_step(input mstate_t m, input int d, input logic r,
                                         input logic a, input logic l);
    mstate_t nx;
    logic    rs;
    logic    running;
    nx      = m;
    rs      = m.sq[ns(d)-1];
    running = (m.quiet >= hc(d) + sc(d)) && (m.l2_left == 0);
    if (r) begin
      nx.quiet   = 0;
      nx.l2_left = 0;
      nx.sq      = '0;
    end else begin
      if (rs) begin
        nx.quiet   = 0;
        nx.l2_left = 0;
      end else begin
        if (m.quiet < 1000000) nx.quiet = m.quiet + 1;
        if (m.l2_left > 0) nx.l2_left = m.l2_left - 1;
        else if (running && l) nx.l2_left = hc(d);
      end
      nx.sq = {m.sq[6:0], a};
    end
    return nx;
  endfunction

  function automatic int pk(input int s0, input int s1, input int rdy, input int st);
    return s0 * 16 + s1 * 8 + rdy * 4 + st;
  endfunction

  function automatic int exp_outs(input int d);
    int st;
    if (ms[d].quiet < hc(d))              st = 0;
    else if (ms[d].quiet < hc(d) + sc(d)) st = 1;
    else if (ms[d].l2_left > 0)           st = 3;
    else                                  st = 2;
    return pk(int'(st == 0), int'(st != 2), int'(st == 2), st);
  endfunction

  function automatic int outs_a();
    return pk(int'(ifa.auto_out_member_subsystem_sbus_0_reset),
              int'(ifa.auto_out_member_subsystem_sbus_1_reset),
              int'(ifa.io_ready), int'(ifa.io_state));
  endfunction

  function automatic int outs_b();
    return pk(int'(ifb.auto_out_member_subsystem_sbus_0_reset),
              int'(ifb.auto_out_member_subsystem_sbus_1_reset),
              int'(ifb.io_ready), int'(ifb.io_state));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    ms[0] <= model_step(ms[0], 0, rst_a, ifa.io_async_req, ifa.io_l2_reset_req);
    ms[1] <= model_step(ms[1], 1, rst_b, ifb.io_async_req, ifb.io_l2_reset_req);
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_A", outs_a(), exp_outs(0));
      check("model_B", outs_b(), exp_outs(1));
      check("order_A", int'(!(ifa.auto_out_member_subsystem_sbus_0_reset &&
                              !ifa.auto_out_member_subsystem_sbus_1_reset)), 1);
      check("order_B", int'(!(ifb.auto_out_member_subsystem_sbus_0_reset &&
                              !ifb.auto_out_member_subsystem_sbus_1_reset)), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in cycle 0 of a release (reset about to be sampled low).
  task automatic powerup_a(input string tag);
    rst_a = 1'b0;
    repeat (15) step();
    check({tag, "_c15"}, outs_a(), pk(1, 1, 0, 0));
    step();
    check({tag, "_c16"}, outs_a(), pk(0, 1, 0, 1));
    repeat (7) step();
    check({tag, "_c23"}, outs_a(), pk(0, 1, 0, 1));
    step();
    check({tag, "_c24"}, outs_a(), pk(0, 0, 1, 2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.io_async_req    = 1'b0;
    ifa.io_l2_reset_req = 1'b0;
    ifb.io_async_req    = 1'b0;
    ifb.io_l2_reset_req = 1'b0;
    @(negedge clk);
    repeat (5) step();
    chk_en = 1'b1;
    check("rst_A", outs_a(), pk(1, 1, 0, 0));
    check("rst_B", outs_b(), pk(1, 1, 0, 0));

    powerup_a("pwr");

    // L2-only reset
    repeat (2) step();
    ifa.io_l2_reset_req = 1'b1;
    step();
    ifa.io_l2_reset_req = 1'b0;
    check("l2_state", int'(ifa.io_state), 3);
    n = 0;
    while (ifa.auto_out_member_subsystem_sbus_1_reset && n < 40) begin
      n++;
      step();
    end
    check("l2_hold", n, 16);
    check("l2_back", outs_a(), pk(0, 0, 1, 2));

    // Repeat request inside HOLD1 must not extend the hold
    ifa.io_l2_reset_req = 1'b1;
    step();
    ifa.io_l2_reset_req = 1'b0;
    n = 0;
    while (ifa.auto_out_member_subsystem_sbus_1_reset && n < 40) begin
      n++;
      ifa.io_l2_reset_req = (n == 5);
      step();
      ifa.io_l2_reset_req = 1'b0;
    end
    check("l2_ignored", n, 16);

    // Reset in the middle of HOLD1
    ifa.io_l2_reset_req = 1'b1;
    step();
    ifa.io_l2_reset_req = 1'b0;
    repeat (4) step();
    rst_a = 1'b1;
    step();
    check("midrst", outs_a(), pk(1, 1, 0, 0));
    powerup_a("rerun");

    // Async request during REL0
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (18) step();
    check("rel0_c18", int'(ifa.io_state), 1);
    ifa.io_async_req = 1'b1;
    repeat (3) step();
    check("async_e20", outs_a(), pk(0, 1, 0, 1));
    step();
    check("async_e21", outs_a(), pk(1, 1, 0, 0));
    repeat (6) step();
    ifa.io_async_req = 1'b0;
    n = 0;
    while (ifa.auto_out_member_subsystem_sbus_0_reset && n < 60) begin
      n++;
      step();
    end
    check("async_release", n, 19);
    n = 0;
    while (!ifa.io_ready && n < 40) begin
      n++;
      step();
    end
    check("async_stagger", n, 8);

    // Synchronized request and L2 request together in RUN
    ifa.io_async_req = 1'b1;
    repeat (3) step();
    check("sim_pre", int'(ifa.io_state), 2);
    ifa.io_l2_reset_req = 1'b1;
    step();
    ifa.io_l2_reset_req = 1'b0;
    ifa.io_async_req    = 1'b0;
    check("sim_both", outs_a(), pk(1, 1, 0, 0));

    // L2 request in REL0 is ignored
    n = 0;
    while (ifa.auto_out_member_subsystem_sbus_0_reset && n < 60) begin
      n++;
      step();
    end
    ifa.io_l2_reset_req = 1'b1;
    step();
    ifa.io_l2_reset_req = 1'b0;
    n = 1;
    while (!ifa.io_ready && n < 40) begin
      n++;
      step();
    end
    check("rel0_ignored", n, 8);

    // Parameter corner instance
    rst_b = 1'b0;
    step();
    check("cor_c1", outs_b(), pk(0, 1, 0, 1));
    step();
    check("cor_c2", outs_b(), pk(0, 0, 1, 2));
    ifb.io_async_req = 1'b1;
    repeat (2) step();
    check("cor_lat2", int'(ifb.io_ready), 1);
    step();
    check("cor_lat3", outs_b(), pk(1, 1, 0, 0));
    ifb.io_async_req = 1'b0;
    repeat (6) step();
    check("cor_release", outs_b(), pk(0, 0, 1, 2));

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clock_group_reset_sequencer.md
# clock_group_reset_sequencer

Generates the per-group resets for the system-bus clock groups and drives them into the clock-group aggregation stage. The resets are released in a fixed order: group 0 (sbus) first, then group 1 (L2) after a programmable stagger. The block also accepts an asynchronous external reset request, and a synchronous request that re-resets only the L2 group while the rest of the system keeps running. It runs on a single clock, and every output is a flop.

## Interface
Parameters:
- SYNC_STAGES, default 3: flop depth of the synchronizer on io_async_req. Must be at least 2.
- HOLD_CYCLES, default 16: number of cycles a reset is held after its cause goes away. Range 1 to 2^CNT_W.
- STAGGER_CYCLES, default 8: number of cycles between the group-0 release and the group-1 release. Range 1 to 2^CNT_W.
- CNT_W, default 8: width of the shared down/up counter.

Ports:
- clock, in, 1: the single clock. Reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high block reset.
- io_async_req, in, 1: asynchronous external reset request, level-sensitive, for example from debug or a watchdog.
- io_l2_reset_req, in, 1: synchronous single-cycle request to reset group 1 only.
- auto_out_member_subsystem_sbus_0_reset, out, 1: active-high reset for group 0 (sbus).
- auto_out_member_subsystem_sbus_1_reset, out, 1: active-high reset for group 1 (L2).
- io_ready, out, 1: high when both groups are out of reset.
- io_state, out, 2: current FSM state, for debug.

## Operation
- **Synchronizer.** io_async_req passes through SYNC_STAGES flops. Reset clears the chain to 0. Its output is called req_s.
- **Counter.** One counter, cnt, of width CNT_W. It is cleared to 0 on every state entry and increments by 1 each cycle while counting.
- **FSM states and encodings:**
  - HOLD_ALL = 0: both resets high.
  - REL0 = 1: group 0 released, group 1 still high.
  - RUN = 2: both resets low, io_ready high.
  - HOLD1 = 3: group 0 low, group 1 high.
- **Transitions.** The first matching rule applies:
  - Any state with req_s = 1 goes to HOLD_ALL and cnt is held at 0. HOLD_ALL does not count while req_s = 1.
  - HOLD_ALL with cnt == HOLD_CYCLES-1 goes to REL0.
  - REL0 with cnt == STAGGER_CYCLES-1 goes to RUN.
  - RUN with io_l2_reset_req = 1 goes to HOLD1.
  - HOLD1 with cnt == HOLD_CYCLES-1 goes to RUN.
- **Ignored and merged requests:**
  - io_l2_reset_req is ignored in HOLD_ALL and REL0, where group 1 is already in reset.
  - io_l2_reset_req is ignored in HOLD1; it does not restart the counter.
  - If req_s and io_l2_reset_req are both high in RUN, req_s wins and the next state is HOLD_ALL.
- **Outputs.** Outputs are registered. They are computed from the next state and update on the same edge as the state register:
  - sbus_0_reset = (state == HOLD_ALL)
  - sbus_1_reset = (state != RUN)
  - io_ready = (state == RUN)
  - io_state = state
- **Reset values.** While reset is high:
  - state = HOLD_ALL and cnt = 0.
  - Both reset outputs = 1.
  - io_ready = 0 and io_state = 0.
  - Synchronizer chain = 0.
- **Reset mid-operation.** If reset asserts in any state, the next edge returns the block to the reset values above. The release sequence then restarts from the beginning.
- **Ordering invariant.** sbus_1_reset is never low while sbus_0_reset is high.

## Timing
- **Release after reset.** Cycle 0 is the first cycle in which reset is sampled low.
  - sbus_0_reset falls at the start of cycle HOLD_CYCLES.
  - sbus_1_reset and the io_ready rise both occur at the start of cycle HOLD_CYCLES + STAGGER_CYCLES.
- **Async request assert latency.** When io_async_req rises before edge e, req_s goes high after edge e+SYNC_STAGES-1. Both resets are high after edge e+SYNC_STAGES.
- **Async request release.** When req_s is first sampled low in HOLD_ALL, call that cycle c0. sbus_0_reset falls HOLD_CYCLES cycles after c0, and the standard stagger follows.
- **L2 request.** io_l2_reset_req sampled high in RUN at edge e:
  - sbus_1_reset goes high and io_ready goes low after edge e.
  - Both return after HOLD_CYCLES further cycles.
  - sbus_0_reset stays low throughout.
- **Counter range.** The counter never wraps, because the limits are at most 2^CNT_W.

## Test plan
- **Power-up sequence.** Defaults; reset high for 5 cycles, then low. Required: sbus_0_reset low from cycle 16, sbus_1_reset low and io_ready high from cycle 24, and io_state following 0→1→2.
- **L2-only reset.** In RUN, pulse io_l2_reset_req for 1 cycle. Required: sbus_1_reset high for exactly 16 cycles, sbus_0_reset constantly 0, io_state = 3 during the hold, then io_state = 2.
- **Async request during REL0.** Raise io_async_req at cycle 18 and hold it for 10 cycles. Required: both resets high by edge 21. The release occurs 16 cycles after req_s is seen low, followed by the 8-cycle stagger.
- **Simultaneous requests in RUN.** Assert req_s and io_l2_reset_req in the same cycle. Required: next state 0 and both resets high. Also, io_l2_reset_req pulsed in REL0 or HOLD1 → no state change and no counter restart.
- **Reset mid-HOLD1.** Assert reset at hold cycle 5. Required: both resets high on the next edge, and the full 16+8 sequence repeats after reset is released.
- **Parameter corner.** HOLD_CYCLES=1, STAGGER_CYCLES=1, SYNC_STAGES=2. Required: sbus_0_reset low at cycle 1, sbus_1_reset low at cycle 2, and an async assert latency of 2 edges.
